// File: rtl/reset_sup_pkg.sv
// Shared types and defaults for the reset supervisor: FSM state encoding,
// counter widths, default timing constants and a small state helper.
package reset_sup_pkg;

  typedef enum logic [3:0] {
    BOOT         = 4'd0,
    TRIG_FULL    = 4'd1,
    WAIT_DRST_HI = 4'd2,
    WAIT_DRST_LO = 4'd3,
    TRIG_IDLY    = 4'd4,
    WAIT_IRST_HI = 4'd5,
    WAIT_IRST_LO = 4'd6,
    CHECK        = 4'd7,
    READY        = 4'd8,
    FAIL         = 4'd9
  } state_t;

  localparam int TMO_W = 24;
  localparam int CHK_W = 16;

  // 225 ms and 100 us at 40 MHz.
  localparam logic [TMO_W-1:0] TIMEOUT_CYCLES_DEF = 24'd9_000_000;
  localparam logic [CHK_W-1:0] CHECK_CYCLES_DEF   = 16'd4000;
  localparam int               MAX_RETRIES_DEF    = 3;
  localparam int               LOSS_FILTER_DEF    = 8;

  // READY and FAIL are the only states in which no sequence is running.
  function automatic logic is_idle(input state_t st);
    return (st == READY) || (st == FAIL);
  endfunction

endpackage

// File: rtl/reset_supervisor_if.sv
// Trigger/feedback handshake between the supervisor (master) and reset_ctrl
// (slave). Triggers are single-cycle pulses; feedback is clk40-synchronous.
interface reset_supervisor_if;
  logic full_rst_trig;
  logic idelay_rst_trig;
  logic dcm_rst;
  logic idelay_rst;

  modport master (
    output full_rst_trig,
    output idelay_rst_trig,
    input  dcm_rst,
    input  idelay_rst
  );

  modport slave (
    input  full_rst_trig,
    input  idelay_rst_trig,
    output dcm_rst,
    output idelay_rst
  );
endinterface

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous level into clk40.
module sync_bit (
  input  logic clk40,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture to settle metastability before the level is used.
  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/reset_supervisor.sv
// Reset supervisor: fires full/idelay triggers at reset_ctrl, follows the
// returned dcm_rst/idelay_rst waveforms, verifies DCM lock and IDELAYCTRL
// ready, retries on error and reports status to the host.
// Build option: RESET_SUPERVISOR_AUTO_RELOCK_EN -- when defined, lock loss in
// READY starts a full reset automatically; otherwise it moves to FAIL.
module reset_supervisor
  import reset_sup_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [CHK_W-1:0] CHECK_CYCLES   = CHECK_CYCLES_DEF,
  parameter int               MAX_RETRIES    = MAX_RETRIES_DEF,
  parameter int               LOSS_FILTER    = LOSS_FILTER_DEF
) (
  input  logic                      clk40,
  input  logic                      rst_n,
  input  logic                      host_full_req,
  input  logic                      host_idelay_req,
  input  logic                      dcm_locked,
  input  logic                      idelayctrl_rdy,
  reset_supervisor_if.master        rc,
  output logic                      busy,
  output logic                      ready,
  output logic                      fail,
  output logic [1:0]                retry_cnt,
  output logic                      req_dropped
);

  localparam int               LOSS_W    = $clog2(LOSS_FILTER + 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRIES);

  logic             full_sync_s;
  logic             idly_sync_s;
  logic             locked_sync_s;
  logic             rdy_sync_s;
  logic             full_prev_r;
  logic             idly_prev_r;
  logic             edge_full_s;
  logic             edge_idly_s;

  state_t           state_r;
  state_t           state_next_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [CHK_W-1:0] chk_cnt_r;
  logic [LOSS_W-1:0] loss_cnt_r;
  logic             tmo_hit_s;
  logic             chk_hit_s;
  logic             lock_loss_s;
  logic             seq_err_s;

  logic             fail_r;
  logic             fail_next_s;
  logic [1:0]       retry_r;
  logic [1:0]       retry_next_s;
  logic             dropped_r;
  logic             dropped_next_s;
  logic             busy_r;
  logic             ready_r;
  logic             full_trig_r;
  logic             idly_trig_r;

  sync_bit u_sync_full   (.clk40(clk40), .rst_n(rst_n), .d(host_full_req),   .q(full_sync_s));
  sync_bit u_sync_idly   (.clk40(clk40), .rst_n(rst_n), .d(host_idelay_req), .q(idly_sync_s));
  sync_bit u_sync_locked (.clk40(clk40), .rst_n(rst_n), .d(dcm_locked),      .q(locked_sync_s));
  sync_bit u_sync_rdy    (.clk40(clk40), .rst_n(rst_n), .d(idelayctrl_rdy),  .q(rdy_sync_s));

  // Delay the synchronized host levels by one cycle for rising-edge detection.
  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      full_prev_r <= 1'b0;
      idly_prev_r <= 1'b0;
    end else begin
      full_prev_r <= full_sync_s;
      idly_prev_r <= idly_sync_s;
    end
  end

  assign edge_full_s = full_sync_s & ~full_prev_r;
  assign edge_idly_s = idly_sync_s & ~idly_prev_r;

  assign tmo_hit_s   = (tmo_cnt_r == (TIMEOUT_CYCLES - 24'd1));
  assign chk_hit_s   = (chk_cnt_r == (CHECK_CYCLES - 16'd1));
  assign lock_loss_s = (state_r == READY) && !locked_sync_s && (loss_cnt_r == LOSS_LAST);

  // State timers restart on every state change and count while a state holds.
  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
      chk_cnt_r <= {CHK_W{1'b0}};
    end else if (state_next_s != state_r) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
      chk_cnt_r <= {CHK_W{1'b0}};
    end else begin
      if (!tmo_hit_s) begin
        tmo_cnt_r <= tmo_cnt_r + 24'd1;
      end
      if (!chk_hit_s) begin
        chk_cnt_r <= chk_cnt_r + 16'd1;
      end
    end
  end

  // Count consecutive low cycles of the synchronized lock while in READY.
  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_r <= {LOSS_W{1'b0}};
    end else if ((state_r != READY) || locked_sync_s) begin
      loss_cnt_r <= {LOSS_W{1'b0}};
    end else if (loss_cnt_r != LOSS_LAST) begin
      loss_cnt_r <= loss_cnt_r + LOSS_W'(1);
    end
  end

  // Next-state, sticky status and retry bookkeeping.
  always_comb begin
    state_next_s   = state_r;
    fail_next_s    = fail_r;
    retry_next_s   = retry_r;
    dropped_next_s = dropped_r;
    seq_err_s      = 1'b0;

    case (state_r)
      BOOT:      state_next_s = TRIG_FULL;
      TRIG_FULL: state_next_s = WAIT_DRST_HI;
      TRIG_IDLY: state_next_s = WAIT_IRST_HI;
      WAIT_DRST_HI: begin
        if (rc.dcm_rst)      state_next_s = WAIT_DRST_LO;
        else if (tmo_hit_s)  seq_err_s    = 1'b1;
        else                 state_next_s = state_r;
      end
      WAIT_DRST_LO: begin
        if (!rc.dcm_rst)     state_next_s = WAIT_IRST_HI;
        else if (tmo_hit_s)  seq_err_s    = 1'b1;
        else                 state_next_s = state_r;
      end
      WAIT_IRST_HI: begin
        if (rc.idelay_rst)   state_next_s = WAIT_IRST_LO;
        else if (tmo_hit_s)  seq_err_s    = 1'b1;
        else                 state_next_s = state_r;
      end
      WAIT_IRST_LO: begin
        if (!rc.idelay_rst)  state_next_s = CHECK;
        else if (tmo_hit_s)  seq_err_s    = 1'b1;
        else                 state_next_s = state_r;
      end
      CHECK: begin
        if (locked_sync_s && rdy_sync_s) state_next_s = READY;
        else if (chk_hit_s)              seq_err_s    = 1'b1;
        else                             state_next_s = state_r;
      end
      READY, FAIL: state_next_s = state_r;
      default:     state_next_s = BOOT;
    endcase

    if (is_idle(state_r)) begin
      if (edge_full_s || edge_idly_s) begin
        // Accepted request; coincident lock loss folds into one full reset.
        retry_next_s   = 2'd0;
        fail_next_s    = 1'b0;
        dropped_next_s = 1'b0;
        if (edge_full_s || lock_loss_s) state_next_s = TRIG_FULL;
        else                            state_next_s = TRIG_IDLY;
      end else if (lock_loss_s) begin
`ifdef RESET_SUPERVISOR_AUTO_RELOCK_EN
        retry_next_s = 2'd0;
        state_next_s = TRIG_FULL;
`else
        fail_next_s  = 1'b1;
        state_next_s = FAIL;
`endif
      end else begin
        state_next_s = state_r;
      end
    end else begin
      if (seq_err_s) begin
        // An idelay-only sequence that errors also escalates to a full reset.
        if (retry_r < RETRY_MAX) begin
          retry_next_s = retry_r + 2'd1;
          state_next_s = TRIG_FULL;
        end else begin
          fail_next_s  = 1'b1;
          state_next_s = FAIL;
        end
      end else begin
        retry_next_s = retry_r;
      end
      if (edge_full_s || edge_idly_s) dropped_next_s = 1'b1;
      else                            dropped_next_s = dropped_r;
    end
  end

  // State register and registered outputs aligned with the state they describe.
  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= BOOT;
      fail_r      <= 1'b0;
      retry_r     <= 2'd0;
      dropped_r   <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
      full_trig_r <= 1'b0;
      idly_trig_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      fail_r      <= fail_next_s;
      retry_r     <= retry_next_s;
      dropped_r   <= dropped_next_s;
      busy_r      <= !is_idle(state_next_s);
      ready_r     <= (state_next_s == READY);
      full_trig_r <= (state_next_s == TRIG_FULL);
      idly_trig_r <= (state_next_s == TRIG_IDLY);
    end
  end

  assign rc.full_rst_trig   = full_trig_r;
  assign rc.idelay_rst_trig = idly_trig_r;
  assign busy               = busy_r;
  assign ready              = ready_r;
  assign fail               = fail_r;
  assign retry_cnt          = retry_r;
  assign req_dropped        = dropped_r;

endmodule

// File: doc/reset_supervisor.md
Name: reset_supervisor

Overview:
Supervisor that drives `reset_ctrl` from the other end of its trigger interface. It issues the single-cycle, clk40-synchronous `full_rst_trig` and `idelay_rst_trig` pulses, then follows the returned `dcm_rst`/`idelay_rst` waveforms to completion. It verifies DCM lock and IDELAYCTRL readiness afterwards, retries on failure, and reports status to the host register bank. It sits between the host control registers and `reset_ctrl` in the clk40 domain.

Parameters:
- TIMEOUT_CYCLES, 24'd9_000_000: max cycles to wait for any expected `dcm_rst`/`idelay_rst` edge (225 ms).
- CHECK_CYCLES, 16'd4000: window after a sequence ends in which lock and ready must be seen (100 us).
- MAX_RETRIES, 3: full-reset retries before declaring failure. `retry_cnt` is 2 bits wide.
- LOSS_FILTER, 8: consecutive cycles of synchronized `dcm_locked` low that count as lock loss.

Ports:
- clk40  in  1  40 MHz system clock.
- rst_n  in  1  Asynchronous active-low reset.
- host_full_req  in  1  Host level request for a full reset. May be asynchronous; it is synchronized and rising-edge detected.
- host_idelay_req  in  1  Host level request for an idelay-only reset. Handled the same way as `host_full_req`.
- dcm_locked  in  1  DCM LOCKED output. Asynchronous; it is synchronized.
- idelayctrl_rdy  in  1  IDELAYCTRL RDY output. Asynchronous; it is synchronized.
- dcm_rst  in  1  Feedback from `reset_ctrl`, synchronous to clk40.
- idelay_rst  in  1  Feedback from `reset_ctrl`, synchronous to clk40.
- full_rst_trig  out  1  One-cycle pulse to `reset_ctrl`.
- idelay_rst_trig  out  1  One-cycle pulse to `reset_ctrl`.
- busy  out  1  High while a sequence is in progress.
- ready  out  1  High when the clocks are verified good.
- fail  out  1  Sticky; cleared only by an accepted host request or by `rst_n`.
- retry_cnt  out  2  Retries used by the current or last sequence.
- req_dropped  out  1  Sticky; set when a host request arrives while busy. Cleared when the next request is accepted.

Behaviour:
- Reset values: triggers 0, busy 0, ready 0, fail 0, retry_cnt 0, req_dropped 0, state BOOT.
- Synchronizers: `host_full_req`, `host_idelay_req`, `dcm_locked` and `idelayctrl_rdy` each pass through 2 flops. Host requests get one more flop for rising-edge detection.
- States and transitions:
  - BOOT: next cycle goes to TRIG_FULL. A full reset always follows `rst_n` release.
  - TRIG_FULL: assert `full_rst_trig` for exactly 1 cycle, clear the timeout counter, go to WAIT_DRST_HI.
  - WAIT_DRST_HI: wait for `dcm_rst` == 1, then go to WAIT_DRST_LO. `reset_ctrl` raises it 2 cycles after the trigger.
  - WAIT_DRST_LO: wait for `dcm_rst` == 0, then go to WAIT_IRST_HI.
  - TRIG_IDLY: assert `idelay_rst_trig` for 1 cycle, then go to WAIT_IRST_HI.
  - WAIT_IRST_HI: wait for `idelay_rst` == 1, then go to WAIT_IRST_LO.
  - WAIT_IRST_LO: wait for `idelay_rst` == 0, then go to CHECK.
  - CHECK: stay up to CHECK_CYCLES. Go to READY on the first cycle with `dcm_locked` & `idelayctrl_rdy` both synchronized high.
  - READY and FAIL: idle states; see host and lock-loss rules below.
- Each WAIT state restarts the 24-bit timeout counter on entry. Hitting TIMEOUT_CYCLES in any WAIT state, or expiry of the CHECK window, is a sequence error.
- Sequence error:
  - If retry_cnt < MAX_RETRIES: increment retry_cnt and go to TRIG_FULL. This applies even when the sequence started as an idelay-only reset.
  - Otherwise: go to FAIL and set `fail`.
- busy = 1 in every state except READY and FAIL. ready = 1 only in READY.
- Host requests are accepted only in READY or FAIL:
  - On acceptance: clear retry_cnt, fail and req_dropped.
  - A full request goes to TRIG_FULL; an idelay request goes to TRIG_IDLY.
  - If both edges arrive in the same cycle, full wins.
  - An edge arriving while busy is ignored and sets `req_dropped`.
- Lock loss in READY: `dcm_locked` synchronized low for LOSS_FILTER consecutive cycles. The behaviour depends on AUTO_RELOCK_EN (see Optional Feature).
- Lock loss and a host request in the same cycle: the full reset path is taken, once only.
- `rst_n` asserted mid-sequence: everything returns to reset values immediately. `reset_ctrl` may still be mid-sequence when `rst_n` releases and will ignore the BOOT trigger. In that case the WAIT timeout and retry path recovers; no special handling is added.
- The trigger outputs are registered and are never high in two consecutive cycles.

Optional Feature:
- Macro: RESET_SUPERVISOR_AUTO_RELOCK_EN.
- Defined: lock loss in READY goes to TRIG_FULL with retry_cnt cleared. `ready` drops on that same cycle.
- Undefined: lock loss moves READY to FAIL and sets `fail`; no automatic trigger is issued. The host must request the reset.

Decomposition:
- Package `reset_sup_pkg`:
  - State enum (BOOT, TRIG_FULL, WAIT_DRST_HI, WAIT_DRST_LO, TRIG_IDLY, WAIT_IRST_HI, WAIT_IRST_LO, CHECK, READY, FAIL).
  - Default timing constants.
  - Counter widths: timeout 24, check 16.
- Sub-module `sync_bit`: 2-flop synchronizer with asynchronous active-low reset, instantiated 4 times.

Test Plan (TIMEOUT_CYCLES=100, CHECK_CYCLES=10, LOSS_FILTER=4; behavioural `reset_ctrl` model with the full hold shortened to 50 cycles):
- Release `rst_n`, lock and rdy held high -> `full_rst_trig` pulses 2 cycles after release. `dcm_rst` high 50 cycles, then `idelay_rst` 10 cycles. `ready` = 1 within 2 sync cycles of CHECK entry; retry_cnt = 0.
- Keep `dcm_locked` = 0 throughout -> exactly 4 full triggers (1 initial + 3 retries). Then `fail` = 1, retry_cnt = 3, busy = 0.
- In READY, pulse `host_idelay_req` high for 3 cycles -> one `idelay_rst_trig` 3 cycles later, no `full_rst_trig`, then READY again.
- Model drops the trigger (no `dcm_rst` response) -> after 100 cycles in WAIT_DRST_HI, a retry trigger fires and retry_cnt = 1.
- In READY, drop `dcm_locked` for 3 cycles -> no action. Drop it for 4 cycles -> with AUTO_RELOCK_EN a full trigger fires; without it, state goes to FAIL and `fail` = 1.
- Assert `host_full_req` while busy -> `req_dropped` = 1, no extra trigger. Raise `host_full_req` and `host_idelay_req` in the same cycle in READY -> only `full_rst_trig` fires.
